// File: rtl/midi_msg_assembler.sv
// Assembles a raw MIDI byte stream into 24-bit channel messages and holds one message while the handler is busy.
// Optional macro RUNNING_STATUS_EN: data bytes after a completed message reuse the latched status.
module midi_msg_assembler #(
  parameter logic       OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        handler_busy,
  output logic [23:0] msg,
  output logic        new_msg,
  output logic        overrun
);

  typedef enum logic [2:0] {NO_STATUS, WAIT_D1, WAIT_D2, SKIP, SKIP_DATA} state_t;

`ifdef RUNNING_STATUS_EN
  localparam state_t AFTER_MSG = WAIT_D1;
`else
  localparam state_t AFTER_MSG = NO_STATUS;
`endif

  state_t      state_q, state_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  data1_q, data1_d;
  logic        two_q, two_d;
  logic [1:0]  skip_q, skip_d;
  logic [23:0] msg_q, msg_d;
  logic        new_msg_q, new_msg_d;
  logic        overrun_q, overrun_d;
  logic        pend_valid_q, pend_valid_d;
  logic [23:0] pend_msg_q, pend_msg_d;

  logic        done;
  logic [23:0] done_msg;
  logic        accept;
  logic        deliver_ok;

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    data1_d      = data1_q;
    two_d        = two_q;
    skip_d       = skip_q;
    msg_d        = msg_q;
    new_msg_d    = 1'b0;
    overrun_d    = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_msg_d   = pend_msg_q;
    done         = 1'b0;
    done_msg     = '0;

    // Real-time bytes (F8..FF) fall outside this branch and leave everything untouched.
    if (byte_valid && (byte_data < 8'hF8)) begin
      if (byte_data[7]) begin
        if (byte_data[7:4] != 4'hF) begin
          status_d = byte_data;
          two_d    = !((byte_data[7:4] == 4'hC) || (byte_data[7:4] == 4'hD));
          state_d  = WAIT_D1;
        end else begin
          status_d = '0;
          case (byte_data[3:0])
            4'h0:        state_d = SKIP;
            4'h1, 4'h3:  begin skip_d = 2'd1; state_d = SKIP_DATA; end
            4'h2:        begin skip_d = 2'd2; state_d = SKIP_DATA; end
            default:     state_d = NO_STATUS;
          endcase
        end
      end else begin
        case (state_q)
          WAIT_D1: begin
            if (two_q) begin
              data1_d = byte_data;
              state_d = WAIT_D2;
            end else begin
              done     = 1'b1;
              done_msg = {8'h00, byte_data, status_q};
              state_d  = AFTER_MSG;
            end
          end
          WAIT_D2: begin
            done     = 1'b1;
            done_msg = {byte_data, data1_q, status_q};
            state_d  = AFTER_MSG;
          end
          SKIP_DATA: begin
            skip_d = skip_q - 2'd1;
            if (skip_q == 2'd1) state_d = NO_STATUS;
          end
          default: ;
        endcase
      end
    end

    accept     = done && (OMNI || (done_msg[3:0] == CHANNEL));
    // new_msg_q high means the handler has not yet had a cycle to raise busy.
    deliver_ok = !new_msg_q && !handler_busy;

    if (pend_valid_q && deliver_ok) begin
      msg_d        = pend_msg_q;
      new_msg_d    = 1'b1;
      pend_valid_d = accept;
      if (accept) pend_msg_d = done_msg;
    end else if (accept) begin
      if (!pend_valid_q && deliver_ok) begin
        msg_d     = done_msg;
        new_msg_d = 1'b1;
      end else if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_msg_d   = done_msg;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= NO_STATUS;
      status_q     <= '0;
      data1_q      <= '0;
      two_q        <= 1'b0;
      skip_q       <= '0;
      msg_q        <= '0;
      new_msg_q    <= 1'b0;
      overrun_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_msg_q   <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      data1_q      <= data1_d;
      two_q        <= two_d;
      skip_q       <= skip_d;
      msg_q        <= msg_d;
      new_msg_q    <= new_msg_d;
      overrun_q    <= overrun_d;
      pend_valid_q <= pend_valid_d;
      pend_msg_q   <= pend_msg_d;
    end
  end

  assign msg     = msg_q;
  assign new_msg = new_msg_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_midi_msg_assembler.sv
// Scoreboard bench: an omni instance and a channel-1 instance share one randomized MIDI byte stream.
module tb_midi_msg_assembler;

  logic        clk = 1'b0;
  logic        reset, byte_valid, handler_busy;
  logic [7:0]  byte_data;
  logic [23:0] msg_a, msg_b;
  logic        new_a, new_b, ovr_a, ovr_b;

  always #5 clk = ~clk;

  midi_msg_assembler dut_a (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .handler_busy(handler_busy), .msg(msg_a), .new_msg(new_a), .overrun(ovr_a)
  );

  midi_msg_assembler #(.OMNI(1'b0), .CHANNEL(4'd1)) dut_b (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .handler_busy(handler_busy), .msg(msg_b), .new_msg(new_b), .overrun(ovr_b)
  );

  typedef struct {
    int          k;
    bit          ovr;
    logic [23:0] m;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned ncyc = 0;
  bit          rst_seen = 1'b0;
  logic [23:0] held [2];

  // Reference model: message parser state
  logic [7:0]  rs;
  bit          rs_v;
  logic [7:0]  got[$];
  bit          in_sysex;
  int          skip_left;
  // Reference model: delivery state per instance
  bit          pend_v [2];
  logic [23:0] pend_m [2];
  bit          guard  [2];

  always @(posedge clk) begin
    ncyc     <= ncyc + 1;
    rst_seen <= reset;
  end

  function automatic int need(input logic [7:0] s);
    return ((s[7:4] == 4'hC) || (s[7:4] == 4'hD)) ? 1 : 2;
  endfunction

  function automatic int first_of(input int k, input bit ovr);
    for (int i = 0; i < q.size(); i++)
      if (q[i].k == k && q[i].ovr == ovr) return i;
    return -1;
  endfunction

  task automatic model_reset();
    got.delete();
    rs_v = 0; rs = '0; in_sysex = 0; skip_left = 0;
    for (int k = 0; k < 2; k++) begin
      pend_v[k] = 0; pend_m[k] = '0; guard[k] = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output bit done, output logic [23:0] m);
    done = 0;
    m    = '0;
    if (b >= 8'hF8) return;
    if (b[7]) begin
      got.delete();
      in_sysex  = 0;
      skip_left = 0;
      if (b < 8'hF0) begin
        rs = b; rs_v = 1;
      end else begin
        rs_v = 0;
        if (b == 8'hF0) in_sysex = 1;
        else if (b == 8'hF1 || b == 8'hF3) skip_left = 1;
        else if (b == 8'hF2) skip_left = 2;
      end
    end else if (in_sysex) begin
    end else if (skip_left > 0) begin
      skip_left--;
    end else if (rs_v) begin
      got.push_back(b);
      if (got.size() == need(rs)) begin
        done = 1;
        m = {(got.size() == 2) ? got[1] : 8'h00, got[0], rs};
        got.delete();
`ifndef RUNNING_STATUS_EN
        rs_v = 0;
`endif
      end
    end
  endtask

  task automatic push_exp(input int k, input bit ovr, input logic [23:0] m, input int unsigned due);
    exp_t e;
    e.k = k; e.ovr = ovr; e.m = m; e.due = due;
    q.push_back(e);
  endtask

  task automatic model_deliver(input int k, input bit c, input logic [23:0] cm, input bit busy,
                               input int unsigned due);
    bit ok, del;
    ok  = !guard[k] && !busy;
    del = 0;
    if (pend_v[k] && ok) begin
      push_exp(k, 0, pend_m[k], due);
      del = 1;
      pend_v[k] = c;
      if (c) pend_m[k] = cm;
    end else if (c) begin
      if (!pend_v[k] && ok) begin
        push_exp(k, 0, cm, due);
        del = 1;
      end else if (!pend_v[k]) begin
        pend_v[k] = 1;
        pend_m[k] = cm;
      end else begin
        push_exp(k, 1, '0, due);
      end
    end
    guard[k] = del;
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit busy);
    bit c;
    logic [23:0] cm;
    @(negedge clk);
    reset = 0; byte_valid = v; byte_data = b; handler_busy = busy;
    c = 0; cm = '0;
    if (v) model_byte(b, c, cm);
    model_deliver(0, c, cm, busy, ncyc + 1);
    model_deliver(1, c && (cm[3:0] == 4'd1), cm, busy, ncyc + 1);
  endtask

  task automatic sb(input logic [7:0] b, input bit busy);
    step(1'b1, b, busy);
  endtask

  task automatic idle(input int n, input bit busy);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), busy);
  endtask

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1; byte_valid = 1'($urandom); byte_data = 8'($urandom); handler_busy = 1'($urandom);
    end
    model_reset();
    @(negedge clk);
    chk("reset msg_a", msg_a, '0);
    chk("reset new_a", {23'd0, new_a}, '0);
    chk("reset ovr_a", {23'd0, ovr_a}, '0);
    chk("reset msg_b", msg_b, '0);
    chk("reset new_b", {23'd0, new_b}, '0);
    chk("reset ovr_b", {23'd0, ovr_b}, '0);
  endtask

  task automatic check_dut(input int k, input logic [23:0] m, input logic nm, input logic ov);
    int i;
    exp_t e;
    for (int o = 0; o < 2; o++) begin
      i = first_of(k, o != 0);
      while (i >= 0 && q[i].due < ncyc) begin
        checks++; errors++;
        $display("FAIL dut%0d missed %s: got none, expected msg=%h at cycle %0d",
                 k, (o != 0) ? "overrun" : "new_msg", q[i].m, q[i].due);
        q.delete(i);
        i = first_of(k, o != 0);
      end
    end
    checks++;
    if (nm) begin
      i = first_of(k, 0);
      if (i < 0) begin
        errors++;
        $display("FAIL dut%0d new_msg: got pulse msg=%h at cycle %0d, expected none", k, m, ncyc);
        held[k] = m;
      end else begin
        e = q[i];
        q.delete(i);
        if (m !== e.m || e.due != ncyc) begin
          errors++;
          $display("FAIL dut%0d delivery: got msg=%h at cycle %0d, expected msg=%h at cycle %0d",
                   k, m, ncyc, e.m, e.due);
        end
        held[k] = e.m;
      end
    end else if (m !== held[k]) begin
      errors++;
      $display("FAIL dut%0d msg hold: got %h, expected %h at cycle %0d", k, m, held[k], ncyc);
      held[k] = m;
    end
    if (ov) begin
      checks++;
      i = first_of(k, 1);
      if (i < 0 || q[i].due != ncyc) begin
        errors++;
        $display("FAIL dut%0d overrun: got pulse at cycle %0d, expected %0d", k, ncyc,
                 (i < 0) ? -1 : int'(q[i].due));
      end
      if (i >= 0) q.delete(i);
    end
  endtask

  always @(negedge clk) begin
    if (rst_seen) begin
      held[0] = '0;
      held[1] = '0;
    end
    check_dut(0, msg_a, new_a, ovr_a);
    check_dut(1, msg_b, new_b, ovr_b);
  end

  initial begin
    bit busy;
    int r;
    logic [7:0] b;
    reset = 1; byte_valid = 0; byte_data = '0; handler_busy = 0;
    held[0] = '0; held[1] = '0;
    model_reset();
    do_reset();

    sb(8'h90, 0); sb(8'h3C, 0); sb(8'h64, 0); idle(3, 0);
    sb(8'h40, 0); sb(8'h00, 0); idle(3, 0);
    sb(8'hC2, 0); sb(8'h05, 0); idle(2, 0);
    sb(8'hB0, 0); sb(8'h07, 0); sb(8'hF8, 0); sb(8'h7F, 0); idle(3, 0);
    sb(8'h90, 1); sb(8'h3C, 1); sb(8'h64, 1); sb(8'h80, 1); sb(8'h3C, 1); sb(8'h00, 1);
    idle(3, 1); idle(4, 0);
    sb(8'hF0, 0); sb(8'h7E, 0); sb(8'h01, 0); sb(8'hF7, 0);
    sb(8'h91, 0); sb(8'h40, 0); sb(8'h10, 0); idle(2, 0);
    sb(8'hF2, 0); sb(8'h10, 0); sb(8'h20, 0); idle(2, 0);
    sb(8'h90, 0); sb(8'h3C, 0); sb(8'h64, 0); idle(2, 0);
    sb(8'h91, 0); sb(8'h3C, 0); sb(8'h64, 0); idle(2, 0);
    sb(8'h91, 0); sb(8'h3C, 0);
    do_reset();
    sb(8'h64, 0); idle(3, 0);

    busy = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) busy = !busy;
      if ($urandom_range(0, 1499) == 0) do_reset();
      r = $urandom_range(0, 99);
      if (r < 45)      b = 8'($urandom_range(0, 127));
      else if (r < 65) b = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 3))};
      else if (r < 72) b = 8'($urandom_range(8'hF0, 8'hF7));
      else if (r < 80) b = 8'($urandom_range(8'hF8, 8'hFF));
      else             b = 8'($urandom);
      step(r < 80, b, busy);
    end

    idle(10, 0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding expectations, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
